// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the memory bus controller and its address decoder
package mem_bus_pkg;
  typedef enum logic [1:0] {IDLE, RAM_WAIT, EXT_WAIT, DONE} state_t;
  typedef enum logic [1:0] {REG_EXT, REG_RAM, REG_HOLE} region_t;
  localparam int DEC_HI = 26;
  localparam int DEC_LO = 25;
  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;
endpackage

// File: rtl/mem_region_decode.sv
// mem_region_decode: maps a 27-bit word address to its region and the 26-bit local address
import mem_bus_pkg::*;
module mem_region_decode (
  input  logic [26:0] address,
  output region_t     region,
  output logic [25:0] local_addr
);
  // top two address bits select the region; 00 and 01 both land in the external window
  always_comb region = address[DEC_HI] ? (address[DEC_LO] ? REG_HOLE : REG_RAM) : REG_EXT;
  assign local_addr = address[25:0];
endmodule

// File: rtl/mem_bus_controller.sv
// mem_bus_controller: single-request CPU memory controller (block RAM, req/ack slave, hole); MEM_TIMEOUT_EN adds ext ack timeout
import mem_bus_pkg::*;
module mem_bus_controller #(
  parameter int RAM_AW = 14,
  parameter int RAM_LAT = 1,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [26:0]       cpu_address,
  input  logic [31:0]       cpu_data,
  input  logic              cpu_we,
  input  logic              cpu_start,
  output logic [31:0]       cpu_q,
  output logic              cpu_busy,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_d,
  output logic              ram_we,
  input  logic [31:0]       ram_q,
  output logic [25:0]       ext_addr,
  output logic [31:0]       ext_d,
  output logic              ext_we,
  output logic              ext_req,
  input  logic              ext_ack,
  input  logic [31:0]       ext_q,
  output logic              bus_err
);
  state_t      state;
  region_t     region;
  logic [25:0] local_addr;
  logic [25:0] addr_q;
  logic [31:0] data_q;
  logic        we_q;
  logic [2:0]  lat_cnt;
`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
`else
  assign bus_err = 1'b0;
`endif

  mem_region_decode u_dec (.address(cpu_address), .region(region), .local_addr(local_addr));

  assign cpu_busy = (state == IDLE && cpu_start) || state == RAM_WAIT || state == EXT_WAIT;
  assign ram_addr = addr_q[RAM_AW-1:0];
  assign ram_d    = data_q;
  assign ext_addr = addr_q;
  assign ext_d    = data_q;

  // request sequencer: latch at start, wait on the selected region, then one DONE cycle
  always_ff @(posedge clk)
    if (!reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      lat_cnt <= '0;
      cpu_q   <= '0;
      ram_we  <= 1'b0;
      ext_req <= 1'b0;
      ext_we  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt <= '0;
      bus_err <= 1'b0;
`endif
    end else
      case (state)
        IDLE:
          if (cpu_start) begin
            addr_q  <= local_addr;
            data_q  <= cpu_data;
            we_q    <= cpu_we;
            lat_cnt <= '0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            case (region)
              REG_RAM: begin
                state  <= RAM_WAIT;
                ram_we <= cpu_we;
              end
              REG_EXT: begin
                state   <= EXT_WAIT;
                ext_req <= 1'b1;
                ext_we  <= cpu_we;
              end
              default: begin
                state <= DONE;
                if (!cpu_we) cpu_q <= '0;
              end
            endcase
          end
        RAM_WAIT: begin
          ram_we <= 1'b0;
          if (we_q) state <= DONE;
          else if (lat_cnt == 3'(RAM_LAT - 1)) begin
            cpu_q <= ram_q;
            state <= DONE;
          end else lat_cnt <= lat_cnt + 3'd1;
        end
        EXT_WAIT:
          if (ext_ack) begin
            ext_req <= 1'b0;
            ext_we  <= 1'b0;
            if (!we_q) cpu_q <= ext_q;
            state <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            ext_req <= 1'b0;
            ext_we  <= 1'b0;
            if (!we_q) cpu_q <= ERR_WORD;
            bus_err <= 1'b1;
            state   <= DONE;
          end else tmo_cnt <= tmo_cnt + TW'(1);
`endif
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_mem_bus_controller.sv
// tb_mem_bus_controller: directed self-checking bench for mem_bus_controller (RAM_LAT=2, TIMEOUT_CYC=8)
module tb_mem_bus_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [26:0] cpu_address = '0;
  logic [31:0] cpu_data = '0;
  logic        cpu_we = 1'b0;
  logic        cpu_start = 1'b0;
  logic [31:0] cpu_q;
  logic        cpu_busy;
  logic [13:0] ram_addr;
  logic [31:0] ram_d;
  logic        ram_we;
  logic [31:0] ram_q = '0;
  logic [25:0] ext_addr;
  logic [31:0] ext_d;
  logic        ext_we;
  logic        ext_req;
  logic        ext_ack = 1'b0;
  logic [31:0] ext_q = '0;
  logic        bus_err;
  logic [31:0] mem [0:(1<<14)-1];
  int compared = 0;
  int mismatched = 0;
  int bc, wc, rc;
  logic [31:0] ram_addr_seen, ext_addr_seen, ext_d_seen, ext_we_seen;

  mem_bus_controller #(.RAM_AW(14), .RAM_LAT(2), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset), .cpu_address(cpu_address), .cpu_data(cpu_data),
    .cpu_we(cpu_we), .cpu_start(cpu_start), .cpu_q(cpu_q), .cpu_busy(cpu_busy),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q),
    .ext_addr(ext_addr), .ext_d(ext_d), .ext_we(ext_we), .ext_req(ext_req),
    .ext_ack(ext_ack), .ext_q(ext_q), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // block RAM model: write on ram_we, registered read data one cycle after the address
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_d;
    ram_q <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // issue one request from a negedge, acking the ack_at-th ext_req cycle; returns at #1 into the first non-busy cycle
  task automatic run(input logic [26:0] a, input logic [31:0] d, input logic w, input int ack_at);
    cpu_address = a; cpu_data = d; cpu_we = w; cpu_start = 1'b1;
    bc = 0; wc = 0; rc = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!cpu_busy) break;
      bc++;
      if (ram_we) begin wc++; ram_addr_seen = 32'(ram_addr); end
      if (ext_req) begin
        rc++;
        ext_addr_seen = 32'(ext_addr);
        ext_d_seen = ext_d;
        ext_we_seen = 32'(ext_we);
      end
      ext_ack = ext_req && rc == ack_at;
      @(negedge clk);
      cpu_start = 1'b0;
      ext_ack = 1'b0;
    end
    cpu_start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1<<14); i++) mem[i] = '0;
    mem[14'h0010] = 32'h12345678;
    repeat (2) @(negedge clk);
    #1;
    check("rst_cpu_q", cpu_q, 32'h0);
    check("rst_busy", 32'(cpu_busy), 32'h0);
    check("rst_ext_req", 32'(ext_req), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    run(27'h4000010, 32'h0, 1'b0, 0);
    check("rd_busy_cycles", 32'(bc), 32'd3);
    check("rd_q", cpu_q, 32'h12345678);
    check("rd_ram_we", 32'(wc), 32'd0);
    @(negedge clk);

    run(27'h4000020, 32'hCAFEBABE, 1'b1, 0);
    check("wr_busy_cycles", 32'(bc), 32'd2);
    check("wr_ram_we_cycles", 32'(wc), 32'd1);
    check("wr_ram_addr", ram_addr_seen, 32'h20);
    check("wr_q_kept", cpu_q, 32'h12345678);
    check("wr_mem", mem[14'h0020], 32'hCAFEBABE);
    @(negedge clk);

    run(27'h6000000, 32'h0, 1'b0, 0);
    check("hole_busy_cycles", 32'(bc), 32'd1);
    check("hole_q", cpu_q, 32'h0);
    cpu_address = 27'h4000010; cpu_start = 1'b1;
    #1;
    check("done_start_busy", 32'(cpu_busy), 32'h0);
    @(negedge clk);
    cpu_start = 1'b0;
    #1;
    check("done_start_ignored", 32'(cpu_busy), 32'h0);
    @(negedge clk);
    #1;
    check("done_start_idle_q", cpu_q, 32'h0);
    @(negedge clk);

    ext_q = 32'hA5A5A5A5;
    run(27'h0001234, 32'h0, 1'b0, 5);
    check("ext_rd_req_cycles", 32'(rc), 32'd5);
    check("ext_rd_busy_cycles", 32'(bc), 32'd6);
    check("ext_rd_addr", ext_addr_seen, 32'h1234);
    check("ext_rd_we", ext_we_seen, 32'h0);
    check("ext_rd_q", cpu_q, 32'hA5A5A5A5);
    check("ext_rd_req_drop", 32'(ext_req), 32'h0);
    @(negedge clk);

    ext_q = 32'h0BADF00D;
    run(27'h1000100, 32'h11112222, 1'b1, 2);
    check("ext_wr_req_cycles", 32'(rc), 32'd2);
    check("ext_wr_addr", ext_addr_seen, 32'h1000100);
    check("ext_wr_d", ext_d_seen, 32'h11112222);
    check("ext_wr_we", ext_we_seen, 32'h1);
    check("ext_wr_q_kept", cpu_q, 32'hA5A5A5A5);
    @(negedge clk);

    cpu_address = 27'h0000055; cpu_we = 1'b0; cpu_start = 1'b1;
    @(negedge clk);
    cpu_start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mid_req_before", 32'(ext_req), 32'h1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_req", 32'(ext_req), 32'h0);
    check("rst_mid_busy", 32'(cpu_busy), 32'h0);
    check("rst_mid_q", cpu_q, 32'h0);
    ext_q = 32'hFFFF0000; ext_ack = 1'b1;
    @(negedge clk);
    ext_ack = 1'b0;
    #1;
    check("late_ack_q", cpu_q, 32'h0);
    check("late_ack_busy", 32'(cpu_busy), 32'h0);
    check("late_ack_req", 32'(ext_req), 32'h0);
    @(negedge clk);

`ifdef MEM_TIMEOUT_EN
    run(27'h0000077, 32'h0, 1'b0, 0);
    check("tmo_req_cycles", 32'(rc), 32'd8);
    check("tmo_q", cpu_q, 32'hDEADBEEF);
    check("tmo_bus_err", 32'(bus_err), 32'h1);
    check("tmo_req_drop", 32'(ext_req), 32'h0);
    @(negedge clk);
    run(27'h4000010, 32'h0, 1'b0, 0);
    check("tmo_after_rd_q", cpu_q, 32'h12345678);
    check("tmo_err_sticky", 32'(bus_err), 32'h1);
`else
    check("no_tmo_bus_err", 32'(bus_err), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
